// File: rtl/washer_pkg.sv
// -----------------------------------------------------------------------------
// washer_pkg
// Shared constants and types for the washing-machine design. Used by the
// front-panel controller and by the timing block, so encodings of run state,
// wash model and water level live in exactly one place.
// -----------------------------------------------------------------------------
package washer_pkg;

    // Run-state encoding of the control word (2'b11 is never produced)
    localparam logic [1:0] RS_IDLE  = 2'b00;
    localparam logic [1:0] RS_RUN   = 2'b01;
    localparam logic [1:0] RS_PAUSE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = RS_IDLE,
        ST_RUN   = RS_RUN,
        ST_PAUSE = RS_PAUSE
    } run_state_e;

    // Wash model codes
    localparam logic [2:0] MODEL_WRS        = 3'd0; // wash-rinse-spin
    localparam logic [2:0] MODEL_WASH       = 3'd1;
    localparam logic [2:0] MODEL_WASH_RINSE = 3'd2;
    localparam logic [2:0] MODEL_RINSE      = 3'd3;
    localparam logic [2:0] MODEL_RINSE_SPIN = 3'd4;
    localparam logic [2:0] MODEL_SPIN       = 3'd5;

    // Water level range
    localparam logic [2:0] WATER_MIN = 3'd1;
    localparam logic [2:0] WATER_MAX = 3'd5;
    localparam logic [2:0] WATER_DEF = 3'd2;

    // One press pulse per button
    typedef struct packed {
        logic power;
        logic start;
        logic model;
        logic water;
    } press_t;

    // Keep only the highest-priority press of a cycle:
    // power > start > model > water. The others are dropped, not queued.
    function automatic press_t prioritize(input press_t raw);
        press_t res;
        res = '0;
        if (raw.power)      res.power = 1'b1;
        else if (raw.start) res.start = 1'b1;
        else if (raw.model) res.model = 1'b1;
        else if (raw.water) res.water = 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Conditions one raw push-button: 2-flop synchronizer, stability debouncer and
// rising-edge detector. Produces a single-cycle press pulse.
//
// Ports:
//   clk     - system clock
//   rst     - asynchronous active-high reset
//   btn_i   - raw asynchronous button, active-high
//   press_o - one-cycle pulse when the debounced level goes 0->1
//
// A clean raw edge gives press_o high 2 + DEBOUNCE_N cycles after the first
// sampling edge, so registered consumers update one cycle later.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_N = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    // Counter only needs to reach DEBOUNCE_N-1
    localparam int CW = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_N - 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic          db_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    // The debounced level follows the synchronized input only after it has
    // disagreed for DEBOUNCE_N consecutive cycles; any agreement restarts.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press_o = db_q & ~db_prev_q;

endmodule

// File: rtl/washer_panel_ctrl.sv
// -----------------------------------------------------------------------------
// washer_panel_ctrl
// Front-panel controller: turns four raw buttons and the timing block's
// finish flag into the registered control word (power, run state, model,
// water level), sounds a completion buzzer and powers off automatically
// after a finished cycle.
//
// Ports:
//   clk, rst       - 100 MHz clock, asynchronous active-high reset
//   btn_power      - raw power button
//   btn_start      - raw start/pause button
//   btn_model      - raw model-select button
//   btn_water      - raw water-level button
//   finish         - cycle complete (level, synchronous to clk)
//   power_light    - machine powered
//   run_state      - 00 idle, 01 running, 10 paused
//   current_model  - wash model 0..5
//   current_water  - water level 1..5
//   buzzer         - completion alarm
// -----------------------------------------------------------------------------
module washer_panel_ctrl
    import washer_pkg::*;
#(
    parameter int DEBOUNCE_N = 1_000_000,
    parameter int ALARM_N    = 300_000_000,
    parameter int AUTO_OFF_N = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_power,
    input  logic       btn_start,
    input  logic       btn_model,
    input  logic       btn_water,
    input  logic       finish,
    output logic       power_light,
    output logic [1:0] run_state,
    output logic [2:0] current_model,
    output logic [2:0] current_water,
    output logic       buzzer
);

    localparam logic [31:0] ALARM_LIM = 32'(ALARM_N);
    localparam logic [31:0] AUTO_LIM  = 32'(AUTO_OFF_N);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [3:0] raw_btn;
    logic [3:0] press_vec;
    press_t     press_raw, press;

    assign raw_btn = {btn_power, btn_start, btn_model, btn_water};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_N (DEBOUNCE_N)
            ) u_db (
                .clk     (clk),
                .rst     (rst),
                .btn_i   (raw_btn[gi]),
                .press_o (press_vec[gi])
            );
        end
    endgenerate

    assign press_raw = press_t'(press_vec);
    assign press     = prioritize(press_raw);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    run_state_e  state_q, state_d;
    logic        power_q, power_d;
    logic [2:0]  model_q, model_d;
    logic [2:0]  water_q, water_d;
    logic        buzzer_q, buzzer_d;
    logic [31:0] alarm_cnt_q, alarm_cnt_d;
    logic [31:0] auto_cnt_q, auto_cnt_d;
    logic        auto_act_q, auto_act_d;
    logic        fin_q;
    logic        fin_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            power_q     <= 1'b0;
            model_q     <= MODEL_WRS;
            water_q     <= WATER_DEF;
            buzzer_q    <= 1'b0;
            alarm_cnt_q <= '0;
            auto_cnt_q  <= '0;
            auto_act_q  <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            power_q     <= power_d;
            model_q     <= model_d;
            water_q     <= water_d;
            buzzer_q    <= buzzer_d;
            alarm_cnt_q <= alarm_cnt_d;
            auto_cnt_q  <= auto_cnt_d;
            auto_act_q  <= auto_act_d;
            fin_q       <= finish;
        end
    end

    // finish is already synchronous; a rise only matters while powered
    assign fin_rise = finish & ~fin_q & power_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        power_d     = power_q;
        model_d     = model_q;
        water_d     = water_q;
        buzzer_d    = buzzer_q;
        alarm_cnt_d = alarm_cnt_q;
        auto_cnt_d  = auto_cnt_q;
        auto_act_d  = auto_act_q;

        if (press.power) begin
            // Both directions land on the same defaults; powering off
            // additionally silences the alarm and cancels both counters.
            power_d     = ~power_q;
            state_d     = ST_IDLE;
            model_d     = MODEL_WRS;
            water_d     = WATER_DEF;
            buzzer_d    = 1'b0;
            alarm_cnt_d = '0;
            auto_cnt_d  = '0;
            auto_act_d  = 1'b0;
        end else begin
            if (press.start && power_q && !finish) begin
                case (state_q)
                    ST_IDLE:  state_d = ST_RUN;
                    ST_RUN:   state_d = ST_PAUSE;
                    ST_PAUSE: state_d = ST_RUN;
                    default:  state_d = ST_IDLE;
                endcase
            end

            if (press.model && power_q && state_q == ST_IDLE) begin
                model_d = (model_q == MODEL_SPIN) ? MODEL_WRS : model_q + 3'd1;
            end

            if (press.water && power_q && state_q == ST_IDLE) begin
                water_d = (water_q == WATER_MAX) ? WATER_MIN : water_q + 3'd1;
            end

            if (power_q) begin
                if (fin_rise) begin
                    // Count starts at 1 so the terminal compare against the
                    // limit yields exactly ALARM_N / AUTO_OFF_N cycles.
                    buzzer_d    = 1'b1;
                    alarm_cnt_d = 32'd1;
                    auto_act_d  = 1'b1;
                    auto_cnt_d  = 32'd1;
                end else begin
                    if (buzzer_q) begin
                        if (alarm_cnt_q >= ALARM_LIM) begin
                            buzzer_d = 1'b0;
                        end else begin
                            alarm_cnt_d = alarm_cnt_q + 32'd1;
                        end
                    end

                    if (auto_act_q) begin
                        if (auto_cnt_q >= AUTO_LIM) begin
                            power_d     = 1'b0;
                            state_d     = ST_IDLE;
                            model_d     = MODEL_WRS;
                            water_d     = WATER_DEF;
                            buzzer_d    = 1'b0;
                            alarm_cnt_d = '0;
                            auto_cnt_d  = '0;
                            auto_act_d  = 1'b0;
                        end else begin
                            auto_cnt_d = auto_cnt_q + 32'd1;
                        end
                    end
                end
            end
        end
    end

    assign power_light   = power_q;
    assign run_state     = state_q;
    assign current_model = model_q;
    assign current_water = water_q;
    assign buzzer        = buzzer_q;

endmodule

// File: tb/tb_washer_panel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_washer_panel_ctrl
// Directed and randomized stimulus against a simple behavioural model of the
// panel rules (power, run state, model, water as plain integers).
// -----------------------------------------------------------------------------
module tb_washer_panel_ctrl;

    localparam int DN  = 4;
    localparam int AN  = 8;
    localparam int AON = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;     // [3] power, [2] start, [1] model, [0] water
    logic       finish;
    logic       power_light;
    logic [1:0] run_state;
    logic [2:0] current_model;
    logic [2:0] current_water;
    logic       buzzer;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model
    int m_pw, m_rs, m_md, m_wt;

    always #5 clk = ~clk;

    washer_panel_ctrl #(
        .DEBOUNCE_N (DN),
        .ALARM_N    (AN),
        .AUTO_OFF_N (AON)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_power     (btn[3]),
        .btn_start     (btn[2]),
        .btn_model     (btn[1]),
        .btn_water     (btn[0]),
        .finish        (finish),
        .power_light   (power_light),
        .run_state     (run_state),
        .current_model (current_model),
        .current_water (current_water),
        .buzzer        (buzzer)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".power"}, {31'd0, power_light}, m_pw);
        chk({tag, ".run"},   {30'd0, run_state},   m_rs);
        chk({tag, ".model"}, {29'd0, current_model}, m_md);
        chk({tag, ".water"}, {29'd0, current_water}, m_wt);
        chk({tag, ".buzz"},  {31'd0, buzzer}, 0);
        $display("[TB] %s pw=%0d rs=%0d model=%0d water=%0d", tag,
                 power_light, run_state, current_model, current_water);
    endtask

    task automatic model_reset();
        m_pw = 0; m_rs = 0; m_md = 0; m_wt = 2;
    endtask

    // One press resolved by priority; finish is low whenever this is used
    task automatic model_apply(input logic [3:0] m);
        if (m[3]) begin
            m_pw = (m_pw == 0) ? 1 : 0;
            m_rs = 0; m_md = 0; m_wt = 2;
        end else if (m[2]) begin
            if (m_pw == 1) m_rs = (m_rs == 1) ? 2 : 1;
        end else if (m[1]) begin
            if (m_pw == 1 && m_rs == 0) m_md = (m_md + 1) % 6;
        end else if (m[0]) begin
            if (m_pw == 1 && m_rs == 0) m_wt = (m_wt % 5) + 1;
        end
    endtask

    // Clean press: hold long enough to debounce, then release and settle
    task automatic press(input logic [3:0] m, input int hold);
        @(negedge clk);
        btn = m;
        repeat (hold) @(negedge clk);
        btn = 4'b0;
        repeat (10) @(negedge clk);
        model_apply(m);
    endtask

    initial begin
        logic [3:0] mask;

        rst = 1'b1; btn = 4'b0; finish = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all("post_reset");

        // Press latency: 2 sync + DN + 1 cycles
        btn = 4'b1000;
        repeat (6) @(negedge clk);
        chk("latency.before", {31'd0, power_light}, 0);
        @(negedge clk);
        chk("latency.after", {31'd0, power_light}, 1);
        repeat (3) @(negedge clk);
        btn = 4'b0;
        repeat (10) @(negedge clk);
        model_apply(4'b1000);
        chk_all("power_on");

        press(4'b1000, 10); chk_all("power_off");
        press(4'b1000, 10); chk_all("power_on2");

        for (int i = 0; i < 7; i++) begin
            press(4'b0010, 10);
            chk_all($sformatf("model%0d", i));
        end
        chk("model_seq_end", {29'd0, current_model}, 1);

        for (int i = 0; i < 5; i++) begin
            press(4'b0001, 10);
            chk_all($sformatf("water%0d", i));
        end
        chk("water_seq_end", {29'd0, current_water}, 2);

        press(4'b0100, 10); chk_all("start_run");
        press(4'b0010, 10); chk_all("model_while_run");
        press(4'b0001, 10); chk_all("water_while_run");
        press(4'b0100, 10); chk_all("start_pause");
        press(4'b0100, 10); chk_all("start_resume");

        press(4'b1000, 10); chk_all("off_from_run");
        press(4'b0100, 10); chk_all("start_unpowered");
        press(4'b1000, 10); chk_all("power_on3");

        // Short glitches never register
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            btn = 4'b0100;
            repeat (DN - 1) @(negedge clk);
            btn = 4'b0;
            repeat (5) @(negedge clk);
        end
        chk_all("glitch");

        // Long hold gives exactly one transition
        press(4'b0100, 100); chk_all("hold100");
        press(4'b0100, 10);  chk_all("pause2");
        press(4'b0100, 10);  chk_all("run2");

        // Finish while running: buzzer, start ignored, auto power-off
        @(negedge clk);
        finish = 1'b1;
        btn = 4'b0100;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (j == 10) btn = 4'b0;
            chk($sformatf("finA.buzz@%0d", j), {31'd0, buzzer}, (j <= AN) ? 1 : 0);
            chk($sformatf("finA.pw@%0d", j), {31'd0, power_light}, (j < AON + 1) ? 1 : 0);
            chk($sformatf("finA.rs@%0d", j), {30'd0, run_state}, (j < AON + 1) ? 1 : 0);
        end
        finish = 1'b0;
        repeat (10) @(negedge clk);
        model_reset();
        chk_all("auto_off");

        // Finish while unpowered is ignored
        finish = 1'b1;
        repeat (5) @(negedge clk);
        chk("fin_unpowered.buzz", {31'd0, buzzer}, 0);
        finish = 1'b0;
        repeat (3) @(negedge clk);

        // Manual power-off during the alarm window
        press(4'b1000, 10);
        press(4'b0100, 10);
        chk_all("finB.setup");
        @(negedge clk);
        finish = 1'b1;
        btn = 4'b1000;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            if (j == 9) btn = 4'b0;
            chk($sformatf("finB.buzz@%0d", j), {31'd0, buzzer}, (j < 7) ? 1 : 0);
            chk($sformatf("finB.pw@%0d", j), {31'd0, power_light}, (j < 7) ? 1 : 0);
        end
        finish = 1'b0;
        repeat (10) @(negedge clk);
        model_reset();
        chk_all("finB.off");

        // Power and start in the same cycle: power wins
        press(4'b1000, 10); chk_all("power_on4");
        press(4'b1100, 10); chk_all("power_start_same");

        // Asynchronous reset mid-run
        press(4'b1000, 10);
        press(4'b0100, 10);
        chk_all("pre_rst_run");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized presses against the model
        for (int i = 0; i < 40; i++) begin
            mask = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 5) != 0) mask[3] = 1'b0;
            if (mask == 4'b0) mask = 4'b0010;
            press(mask, 8);
            chk_all($sformatf("rand%0d.m%0h", i, mask));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
